// File: rtl/dist_tree_pkg.sv
// Shared sizing helpers for the pipelined distribution tree.
package dist_tree_pkg;

    // Bit value used to build the pruned-branch data word of any width.
    localparam logic DUMMY_BIT = 1'b0;

    function automatic int clog2(input int value);
        int result = 0;
        int span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int tree_levels(input int leaves);
        return (clog2(leaves) < 1) ? 1 : clog2(leaves);
    endfunction

    function automatic int padded_leaves(input int leaves);
        return 1 << tree_levels(leaves);
    endfunction

endpackage

// File: rtl/dist_tree_node_seq.sv
// One registered tree node: stores {valid, data, sub-mask} and splits the
// sub-mask into two children, pruning any child whose half-mask is empty.
module dist_tree_node_seq
    import dist_tree_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MASK_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [MASK_WIDTH-1:0]   in_mask,
    output logic                    lo_valid,
    output logic [DATA_WIDTH-1:0]   lo_data,
    output logic [MASK_WIDTH/2-1:0] lo_mask,
    output logic                    hi_valid,
    output logic [DATA_WIDTH-1:0]   hi_data,
    output logic [MASK_WIDTH/2-1:0] hi_mask
);
    localparam int HALF = MASK_WIDTH / 2;
    localparam logic [DATA_WIDTH-1:0] DUMMY_DATA = {DATA_WIDTH{DUMMY_BIT}};

    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic [MASK_WIDTH-1:0] mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= DUMMY_DATA;
            mask  <= '0;
        end else if (en) begin
            valid <= in_valid;
            data  <= in_valid ? in_data : DUMMY_DATA;
            mask  <= in_valid ? in_mask : '0;
        end
    end

    assign lo_valid = valid && (|mask[HALF-1:0]);
    assign hi_valid = valid && (|mask[MASK_WIDTH-1:HALF]);
    assign lo_data  = lo_valid ? data : DUMMY_DATA;
    assign hi_data  = hi_valid ? data : DUMMY_DATA;
    assign lo_mask  = lo_valid ? mask[HALF-1:0] : '0;
    assign hi_mask  = hi_valid ? mask[MASK_WIDTH-1:HALF] : '0;

endmodule

// File: rtl/dist_tree_seq.sv
// Pipelined 1-to-N multicast tree: the root word is replicated one level per
// cycle and emerges LEVELS cycles later on every leaf selected by its mask.
module dist_tree_seq
    import dist_tree_pkg::*;
#(
    parameter int NUM_OUTPUT_DATA = 8,
    parameter int DATA_WIDTH      = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_en,
    input  logic                                  i_valid,
    input  logic [DATA_WIDTH-1:0]                 i_data,
    input  logic [NUM_OUTPUT_DATA-1:0]            i_dest_mask,
    output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
    output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
    output logic                                  o_busy
);
    localparam int LEVELS = tree_levels(NUM_OUTPUT_DATA);
    localparam int P      = padded_leaves(NUM_OUTPUT_DATA);
    localparam int NODES  = 2 * P - 1;

    // Heap-numbered node I/O: entry 0 is the root input, children of n are
    // 2n+1 / 2n+2, and entries P-1 .. 2P-2 are the padded leaves.
    logic [NODES-1:0]        tree_valid;
    logic [DATA_WIDTH-1:0]   tree_data [NODES];
    // Every level's sub-masks tile exactly P bits, so level l lives at [l*P +: P].
    logic [(LEVELS+1)*P-1:0] tree_mask;
    logic [P-1:0]            root_mask;
    logic [P-1:0]            unused_pad;

    always_comb begin
        root_mask = '0;
        root_mask[NUM_OUTPUT_DATA-1:0] = i_dest_mask;
    end

    assign tree_valid[0]     = i_valid && (|root_mask);
    assign tree_data[0]      = tree_valid[0] ? i_data : '0;
    assign tree_mask[P-1:0]  = tree_valid[0] ? root_mask : '0;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int MW = P >> l;
        for (genvar j = 0; j < (1 << l); j++) begin : g_node
            localparam int ID = (1 << l) - 1 + j;
            dist_tree_node_seq #(
                .DATA_WIDTH (DATA_WIDTH),
                .MASK_WIDTH (MW)
            ) u_node (
                .clk      (clk),
                .rst      (rst),
                .en       (i_en),
                .in_valid (tree_valid[ID]),
                .in_data  (tree_data[ID]),
                .in_mask  (tree_mask[l*P + j*MW +: MW]),
                .lo_valid (tree_valid[2*ID+1]),
                .lo_data  (tree_data[2*ID+1]),
                .lo_mask  (tree_mask[(l+1)*P + j*MW +: MW/2]),
                .hi_valid (tree_valid[2*ID+2]),
                .hi_data  (tree_data[2*ID+2]),
                .hi_mask  (tree_mask[(l+1)*P + j*MW + MW/2 +: MW/2])
            );
        end
    end

    for (genvar k = 0; k < P; k++) begin : g_leaf
        if (k < NUM_OUTPUT_DATA) begin : g_real
            assign o_valid[k]                           = tree_valid[P-1+k];
            assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = tree_data[P-1+k];
            assign unused_pad[k]                        = tree_mask[LEVELS*P + k];
        end else begin : g_pad
            assign unused_pad[k] = tree_mask[LEVELS*P + k] ^ tree_valid[P-1+k]
                                 ^ (^tree_data[P-1+k]);
        end
    end

    // A held token always has a non-empty mask, so some child below it is valid.
    assign o_busy = |tree_valid[NODES-1:1];

endmodule
